// File: rtl/npu_input_feeder.sv
// Byte-stream feeder for the NPU core: assembles 8-byte frames in a shadow buffer
// and launches each one into an active buffer that stays stable for the whole run.
module npu_input_feeder #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        CLKEXT,
    input  logic        RST_GLO,
    input  logic        SOFT_CLR,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  NPU_DA,
    output logic [7:0]  NPU_DB,
    output logic [7:0]  NPU_DC,
    output logic [7:0]  NPU_DD,
    output logic [15:0] NPU_BIAS_N1,
    output logic [15:0] NPU_BIAS_N2,
    output logic        NPU_START,
    input  logic        NPU_DONE,
    input  logic        NPU_BUSY,
    output logic        RUNNING,
    output logic [15:0] FRAME_CNT,
    output logic        TIMEOUT_ERR
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    byte_cnt;
    logic          shadow_full;
    logic [7:0]    shadow [8];
    logic [TW-1:0] to_cnt;
    logic [15:0]   frame_cnt;
    logic          take;
    logic          launch;
    logic          to_hit;
    logic          busy_unused;

    // BUSY is informational only; the handshake is driven purely by DONE.
    assign busy_unused = NPU_BUSY;

    assign IN_READY  = !shadow_full && !SOFT_CLR && !RST_GLO;
    assign take      = IN_VALID && IN_READY;
    assign launch    = (state == IDLE) && shadow_full && !SOFT_CLR;
    assign to_hit    = (to_cnt == TO_LAST);
    assign FRAME_CNT = frame_cnt;

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt latched.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (NPU_DONE || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        RUNNING = (state == RUN);
    end

    // NOTE: shadow bytes carry no reset; byte_cnt and shadow_full decide when they are meaningful.
    always_ff @(posedge CLKEXT) begin
        if (take) shadow[byte_cnt] <= IN_DATA;
    end

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            byte_cnt    <= 3'd0;
            shadow_full <= 1'b0;
            to_cnt      <= '0;
            frame_cnt   <= 16'd0;
            TIMEOUT_ERR <= 1'b0;
            NPU_START   <= 1'b0;
            NPU_BIAS_N1 <= 16'd0;
            NPU_BIAS_N2 <= 16'd0;
            NPU_DA      <= 8'd0;
            NPU_DB      <= 8'd0;
            NPU_DC      <= 8'd0;
            NPU_DD      <= 8'd0;
        end else begin
            NPU_START <= launch;

            if (take) begin
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == 3'd7) shadow_full <= 1'b1;
            end

            if (launch) begin
                shadow_full <= 1'b0;
                to_cnt      <= '0;
                NPU_BIAS_N1 <= {shadow[1], shadow[0]};
                NPU_BIAS_N2 <= {shadow[3], shadow[2]};
                NPU_DA      <= shadow[4];
                NPU_DB      <= shadow[5];
                NPU_DC      <= shadow[6];
                NPU_DD      <= shadow[7];
            end else if (state == RUN && !NPU_DONE) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // DONE takes priority over a coincident timeout.
            if (state == RUN) begin
                if (NPU_DONE)    frame_cnt   <= frame_cnt + 16'd1;
                else if (to_hit) TIMEOUT_ERR <= 1'b1;
            end

            if (SOFT_CLR) begin
                byte_cnt    <= 3'd0;
                shadow_full <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: doc/npu_input_feeder.md
# npu_input_feeder

Upstream feeder for the NPU core. It accepts a byte stream over a valid/ready handshake and assembles each 8-byte frame (two 16-bit biases plus four 8-bit lane values) in a shadow buffer. It launches the frame into the NPU with a one-cycle START pulse, holds the lane and bias buffers stable until the NPU reports DONE, and accepts the next frame into the shadow buffer while the current one runs.

## Interface
- TIMEOUT_CYC, 1024: maximum cycles spent in RUN waiting for NPU_DONE before abort; minimum 2.
- CLKEXT  in  1  single clock; all logic is on the rising edge.
- RST_GLO  in  1  reset, synchronous and active-high.
- SOFT_CLR  in  1  flushes the partial or unlaunched frame and clears TIMEOUT_ERR; does not affect an in-flight run.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  feeder accepts a byte this cycle; combinational: !shadow_full & !SOFT_CLR & !RST_GLO.
- NPU_DA, NPU_DB, NPU_DC, NPU_DD  out  8 each  lane data driven to the NPU (active buffer).
- NPU_BIAS_N1, NPU_BIAS_N2  out  16 each  biases driven to the NPU (active buffer).
- NPU_START  out  1  registered one-cycle launch pulse.
- NPU_DONE  in  1  NPU completion pulse.
- NPU_BUSY  in  1  NPU busy; status only, not used for control.
- RUNNING  out  1  high while state is RUN.
- FRAME_CNT  out  16  count of frames completed with NPU_DONE; wraps 0xFFFF to 0.
- TIMEOUT_ERR  out  1  sticky; set when a run is aborted by timeout.

## Operation
- A byte transfers on an edge where IN_VALID & IN_READY is true.
- Byte order: 0 BIAS_N1[7:0], 1 BIAS_N1[15:8], 2 BIAS_N2[7:0], 3 BIAS_N2[15:8], 4 DA, 5 DB, 6 DC, 7 DD.
- A 3-bit byte counter selects the shadow field. On accepting byte 7, the counter wraps to 0 and shadow_full is set.
- State machine has two states, IDLE and RUN.
  - IDLE & shadow_full: on the edge, copy shadow to active, set NPU_START=1, clear shadow_full, zero the timeout counter, go to RUN.
  - RUN & NPU_DONE: go to IDLE and increment FRAME_CNT.
  - RUN & !NPU_DONE & timeout counter == TIMEOUT_CYC-1: go to IDLE and set TIMEOUT_ERR. FRAME_CNT is unchanged.
  - RUN otherwise: increment the timeout counter.
- NPU_START is high only on the cycle after the launch edge and is cleared on the next edge.
- Active buffers change only on launch edges. They hold their value through RUN and after returning to IDLE.
- The shadow buffer may fill during RUN. The next launch happens from IDLE only, so at least one IDLE cycle separates runs.
- NPU_DONE while in IDLE is ignored.
- SOFT_CLR, on the edge: byte counter=0, shadow_full=0, TIMEOUT_ERR=0. State, active buffers and FRAME_CNT are untouched. A byte presented in the same cycle is not accepted, because IN_READY is low.

## Timing
- Reset values: NPU_DA..NPU_DD=0, NPU_BIAS_N1/N2=0, NPU_START=0, RUNNING=0, FRAME_CNT=0, TIMEOUT_ERR=0, IN_READY=0 while RST_GLO is high. Internally state=IDLE, byte counter=0, shadow_full=0.
- Reset during RUN aborts immediately: no FRAME_CNT increment and no TIMEOUT_ERR.
- From IDLE, byte 7 accepted at edge t sets shadow_full. The launch edge is t+1; NPU_START and RUNNING are high from t+1, and NPU_START falls at t+2.
- IN_READY is low from edge t (byte 7) through the launch edge. It rises after the launch edge (t+1) unless SOFT_CLR is high.
- NPU_DONE sampled at edge d returns the block to IDLE and updates FRAME_CNT at d. With shadow_full set, the earliest relaunch edge is d+1.
- NPU_DONE and timeout on the same edge: DONE wins, the frame is counted and TIMEOUT_ERR is not set.
- Back-to-back streaming: the next frame's bytes are accepted during RUN with zero stall, until shadow_full is set again.

## Test plan
- Reset, then stream 34 12 78 56 AA BB CC DD with IN_VALID held high -> NPU_START pulses for exactly one cycle one cycle after the last byte; outputs BIAS_N1=0x1234, BIAS_N2=0x5678, DA..DD=AA,BB,CC,DD; RUNNING=1.
- Load frame B during RUN, then pulse NPU_DONE 10 cycles after START -> FRAME_CNT=1; IN_READY stays low after frame B fills; frame B's START occurs exactly one cycle after DONE; frame A outputs are held until that edge.
- TIMEOUT_CYC=8 with NPU_DONE never asserted -> RUNNING falls 8 cycles after the launch edge; TIMEOUT_ERR=1; FRAME_CNT unchanged; a later SOFT_CLR clears TIMEOUT_ERR.
- Feed 5 bytes, assert SOFT_CLR one cycle with IN_VALID high, then feed 8 fresh bytes -> the SOFT_CLR-cycle byte is dropped; the launched frame contains only the 8 fresh bytes.
- Assert RST_GLO one cycle mid-RUN with a full shadow -> all outputs return to reset values; no START until 8 new bytes arrive.
- Preload FRAME_CNT to 0xFFFF via 65535 runs (or force), then complete one more run -> FRAME_CNT=0x0000.
